// File: rtl/ieeedrv_trkbuf_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : ieeedrv_trkbuf_ctl_if
// Purpose  : SD block-transfer handshake between track-buffer scheduler and SD.
// Revision : 1.0 - initial release
// ============================================================================
interface ieeedrv_trkbuf_ctl_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [3:0]  buf_blk;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        output buf_blk,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        input  buf_blk,
        output sd_ack
    );
endinterface
`default_nettype wire

// File: rtl/ieeedrv_trkbuf_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ieeedrv_trkbuf_ctl
// Purpose  : IEEE drive track-buffer scheduler (SD image <-> 8 KB track buffer).
// Revision : 1.0 - initial release
// ============================================================================
module ieeedrv_trkbuf_ctl #(
    parameter int  SUBDRV   = 2,
    parameter int  TRACKS   = 154,
    parameter int  TRK_BLKS = 16,
    localparam int DRV_W    = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
    input  wire                   clk_sys,
    input  wire                   reset_n,
    input  wire                   img_mounted,
    input  wire                   img_readonly,
    input  wire [DRV_W-1:0]       drv_act,
    input  wire [7:0]             track,
    input  wire                   mtr,
    input  wire                   we,
    output logic                  halt,
    output logic                  loaded,
    ieeedrv_trkbuf_ctl_if.master  sd
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_READY     = 3'd1;
    localparam logic [2:0] ST_SAVE_REQ  = 3'd2;
    localparam logic [2:0] ST_SAVE_WAIT = 3'd3;
    localparam logic [2:0] ST_LOAD_REQ  = 3'd4;
    localparam logic [2:0] ST_LOAD_WAIT = 3'd5;
    localparam logic [7:0] TRK_NONE     = 8'hFF;
    localparam logic [3:0] BLK_LAST     = 4'(TRK_BLKS - 1);

    logic [2:0]       state_q, state_d;
    logic [DRV_W-1:0] cur_drv_q, cur_drv_d;
    logic [7:0]       cur_trk_q, cur_trk_d;
    logic             dirty_q, dirty_d;
    logic [3:0]       blk_q, blk_d;
    logic             mount_pend_q, mount_pend_d;
    logic             mtr_q;
    logic             halt_q, halt_d;
    logic             loaded_q, loaded_d;
    logic             sd_rd_q, sd_rd_d;
    logic             sd_wr_q, sd_wr_d;
    logic [31:0]      sd_lba_q, sd_lba_d;
    logic [3:0]       buf_blk_q, buf_blk_d;

    logic             w_mtr_fall;
    logic             w_tgt_ok;
    logic             w_tgt_chg;
    logic [31:0]      w_lba;

    assign w_mtr_fall = mtr_q & ~mtr;
    assign w_tgt_ok   = (track != TRK_NONE) && mtr;
    assign w_tgt_chg  = (drv_act != cur_drv_q) || (track != cur_trk_q);
    assign w_lba      = ((32'(cur_drv_q) * 32'(TRACKS)) + 32'(cur_trk_q)) * 32'(TRK_BLKS)
                        + 32'(blk_q);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cur_drv_q    <= '0;
            cur_trk_q    <= TRK_NONE;
            dirty_q      <= 1'b0;
            blk_q        <= 4'd0;
            mount_pend_q <= 1'b0;
            mtr_q        <= 1'b0;
            halt_q       <= 1'b1;
            loaded_q     <= 1'b0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_lba_q     <= 32'd0;
            buf_blk_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            cur_drv_q    <= cur_drv_d;
            cur_trk_q    <= cur_trk_d;
            dirty_q      <= dirty_d;
            blk_q        <= blk_d;
            mount_pend_q <= mount_pend_d;
            mtr_q        <= mtr;
            halt_q       <= halt_d;
            loaded_q     <= loaded_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            sd_lba_q     <= sd_lba_d;
            buf_blk_q    <= buf_blk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_drv_d    = cur_drv_q;
        cur_trk_d    = cur_trk_q;
        dirty_d      = dirty_q;
        blk_d        = blk_q;
        mount_pend_d = mount_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (w_tgt_ok) begin
                    state_d      = ST_LOAD_REQ;
                    blk_d        = 4'd0;
                    cur_drv_d    = drv_act;
                    cur_trk_d    = track;
                    mount_pend_d = 1'b0;
                end
            end
            ST_READY: begin
                // A write in the decision cycle still marks the buffer dirty.
                if (we && !img_readonly) dirty_d = 1'b1;
                if (mount_pend_q) begin
                    mount_pend_d = 1'b0;
                    dirty_d      = 1'b0;
                    cur_trk_d    = TRK_NONE;
                    state_d      = ST_IDLE;
                end else if (w_tgt_chg || w_mtr_fall) begin
                    if (dirty_d) begin
                        state_d = ST_SAVE_REQ;
                        blk_d   = 4'd0;
                    end else if (w_tgt_ok) begin
                        state_d   = ST_LOAD_REQ;
                        blk_d     = 4'd0;
                        cur_drv_d = drv_act;
                        cur_trk_d = track;
                    end else begin
                        state_d   = ST_IDLE;
                        cur_trk_d = TRK_NONE;
                    end
                end
            end
            ST_SAVE_REQ: begin
                if (sd.sd_ack) state_d = ST_SAVE_WAIT;
            end
            ST_SAVE_WAIT: begin
                if (!sd.sd_ack) begin
                    if (blk_q == BLK_LAST || img_readonly) begin
                        dirty_d = 1'b0;
                        if (w_tgt_ok && !mount_pend_q) begin
                            state_d   = ST_LOAD_REQ;
                            blk_d     = 4'd0;
                            cur_drv_d = drv_act;
                            cur_trk_d = track;
                        end else begin
                            state_d      = ST_IDLE;
                            cur_trk_d    = TRK_NONE;
                            mount_pend_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_SAVE_REQ;
                        blk_d   = blk_q + 4'd1;
                    end
                end
            end
            ST_LOAD_REQ: begin
                if (sd.sd_ack) state_d = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (!sd.sd_ack) begin
                    if (blk_q == BLK_LAST) begin
                        state_d = ST_READY;
                    end else if (mount_pend_q || w_tgt_chg || !mtr) begin
                        // Restart for the current target; a partial load is never written back.
                        mount_pend_d = 1'b0;
                        blk_d        = 4'd0;
                        if (w_tgt_ok) begin
                            state_d   = ST_LOAD_REQ;
                            cur_drv_d = drv_act;
                            cur_trk_d = track;
                        end else begin
                            state_d   = ST_IDLE;
                            cur_trk_d = TRK_NONE;
                        end
                    end else begin
                        state_d = ST_LOAD_REQ;
                        blk_d   = blk_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cur_trk_d = TRK_NONE;
            end
        endcase
        if (img_readonly) dirty_d      = 1'b0;
        if (img_mounted)  mount_pend_d = 1'b1;
    end

    // Requests trail the REQ state by one cycle so they drop the cycle after ack is seen.
    always_comb begin
        halt_d    = (state_d != ST_READY);
        loaded_d  = (state_d == ST_READY);
        sd_wr_d   = (state_q == ST_SAVE_REQ);
        sd_rd_d   = (state_q == ST_LOAD_REQ);
        sd_lba_d  = w_lba;
        buf_blk_d = blk_q;
    end

    assign halt       = halt_q;
    assign loaded     = loaded_q;
    assign sd.sd_rd   = sd_rd_q;
    assign sd.sd_wr   = sd_wr_q;
    assign sd.sd_lba  = sd_lba_q;
    assign sd.buf_blk = buf_blk_q;

endmodule
`default_nettype wire

// File: tb/tb_ieeedrv_trkbuf_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ieeedrv_trkbuf_ctl
// Purpose  : Directed self-checking bench for ieeedrv_trkbuf_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ieeedrv_trkbuf_ctl;

    typedef struct packed {
        logic        wr;
        logic [31:0] lba;
        logic [3:0]  blk;
    } xfer_t;

    logic       clk_sys      = 1'b0;
    logic       reset_n      = 1'b0;
    logic       img_mounted  = 1'b0;
    logic       img_readonly = 1'b0;
    logic [0:0] drv_act      = 1'b0;
    logic [7:0] track        = 8'hFF;
    logic       mtr          = 1'b0;
    logic       we           = 1'b0;
    logic       halt;
    logic       loaded;

    xfer_t log_q[$];
    int    n_cmp     = 0;
    int    n_bad     = 0;
    bit    both_seen = 1'b0;

    ieeedrv_trkbuf_ctl_if sd ();

    ieeedrv_trkbuf_ctl #(
        .SUBDRV   (2),
        .TRACKS   (154),
        .TRK_BLKS (16)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .drv_act      (drv_act),
        .track        (track),
        .mtr          (mtr),
        .we           (we),
        .halt         (halt),
        .loaded       (loaded),
        .sd           (sd.master)
    );

    always #5 clk_sys = ~clk_sys;

    // SD card model: log each request, ack for one cycle, then wait for the request to drop.
    initial begin
        int st;
        st = 0;
        sd.sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (sd.sd_rd && sd.sd_wr) both_seen = 1'b1;
            case (st)
                0: if (sd.sd_rd || sd.sd_wr) begin
                    log_q.push_back({sd.sd_wr, sd.sd_lba, sd.buf_blk});
                    sd.sd_ack = 1'b1;
                    st = 1;
                end
                1: begin
                    sd.sd_ack = 1'b0;
                    st = 2;
                end
                default: if (!sd.sd_rd && !sd.sd_wr) st = 0;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Waits for loaded; returns number of cycles where halt was low before loaded rose.
    task automatic wait_loaded(input string tag, output int halt_low);
        int k;
        halt_low = 0;
        for (k = 0; k < 800; k++) begin
            @(negedge clk_sys);
            if (loaded === 1'b1) break;
            if (halt !== 1'b1) halt_low++;
        end
        n_cmp++;
        if (loaded !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: loaded=%b after %0d cycles, required 1", tag, loaded, k);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(3);
        n_cmp++; if (halt !== 1'b1)        begin n_bad++; $display("FAIL reset_halt: got %b want 1", halt); end
        n_cmp++; if (loaded !== 1'b0)      begin n_bad++; $display("FAIL reset_loaded: got %b want 0", loaded); end
        n_cmp++; if (sd.sd_rd !== 1'b0)    begin n_bad++; $display("FAIL reset_sd_rd: got %b want 0", sd.sd_rd); end
        n_cmp++; if (sd.sd_wr !== 1'b0)    begin n_bad++; $display("FAIL reset_sd_wr: got %b want 0", sd.sd_wr); end
        n_cmp++; if (sd.sd_lba !== 32'd0)  begin n_bad++; $display("FAIL reset_sd_lba: got %0d want 0", sd.sd_lba); end
        n_cmp++; if (sd.buf_blk !== 4'd0)  begin n_bad++; $display("FAIL reset_buf_blk: got %0d want 0", sd.buf_blk); end
        reset_n = 1'b1;
        cyc(3);
        n_cmp++; if (log_q.size() != 0 || loaded !== 1'b0) begin
            n_bad++; $display("FAIL idle_no_motor: xfers=%0d loaded=%b, want 0/0", log_q.size(), loaded);
        end
    endtask

    task automatic test_load_from_reset();
        int hl;
        xfer_t e;
        log_q.delete();
        drv_act = 1'b0; track = 8'd5; mtr = 1'b1;
        wait_loaded("load5", hl);
        n_cmp++; if (log_q.size() != 16) begin n_bad++; $display("FAIL load5_count: got %0d want 16", log_q.size()); end
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            e.wr = 1'b0; e.lba = 32'(80 + i); e.blk = 4'(i);
            n_cmp++;
            if (log_q[i] !== e) begin
                n_bad++;
                $display("FAIL load5_xfer%0d: got wr=%b lba=%0d blk=%0d want wr=0 lba=%0d blk=%0d",
                         i, log_q[i].wr, log_q[i].lba, log_q[i].blk, e.lba, e.blk);
            end
        end
        n_cmp++; if (hl != 0) begin n_bad++; $display("FAIL load5_halt: halt low %0d cycles while loading, want 0", hl); end
        n_cmp++; if (halt !== 1'b0 || loaded !== 1'b1) begin
            n_bad++; $display("FAIL load5_ready: halt=%b loaded=%b want 0/1", halt, loaded);
        end
    endtask

    task automatic test_clean_change();
        int hl;
        log_q.delete();
        track = 8'd6;
        @(posedge clk_sys); #1;
        n_cmp++; if (halt !== 1'b1 || loaded !== 1'b0) begin
            n_bad++; $display("FAIL clean_halt_edge: halt=%b loaded=%b want 1/0", halt, loaded);
        end
        wait_loaded("clean6", hl);
        n_cmp++; if (log_q.size() != 16) begin n_bad++; $display("FAIL clean6_count: got %0d want 16", log_q.size()); end
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i].wr !== 1'b0 || log_q[i].lba !== 32'(96 + i)) begin
                n_bad++;
                $display("FAIL clean6_xfer%0d: got wr=%b lba=%0d want wr=0 lba=%0d", i, log_q[i].wr, log_q[i].lba, 96 + i);
            end
        end
    endtask

    task automatic test_dirty_change();
        int hl;
        xfer_t e;
        drv_act = 1'b1; track = 8'd10;
        wait_loaded("goto_1_10", hl);
        log_q.delete();
        we = 1'b1;
        cyc(1);
        we = 1'b0; track = 8'd11;
        wait_loaded("dirty11", hl);
        n_cmp++; if (log_q.size() != 32) begin n_bad++; $display("FAIL dirty11_count: got %0d want 32", log_q.size()); end
        for (int i = 0; i < 32 && i < log_q.size(); i++) begin
            e.wr  = (i < 16);
            e.lba = (i < 16) ? 32'(2624 + i) : 32'(2640 + i - 16);
            e.blk = 4'(i % 16);
            n_cmp++;
            if (log_q[i] !== e) begin
                n_bad++;
                $display("FAIL dirty11_xfer%0d: got wr=%b lba=%0d blk=%0d want wr=%b lba=%0d blk=%0d",
                         i, log_q[i].wr, log_q[i].lba, log_q[i].blk, e.wr, e.lba, e.blk);
            end
        end
        n_cmp++; if (hl != 0) begin n_bad++; $display("FAIL dirty11_halt: halt low %0d cycles, want 0", hl); end
    endtask

    task automatic test_we_with_change();
        int hl;
        log_q.delete();
        we = 1'b1; track = 8'd12;
        cyc(1);
        we = 1'b0;
        wait_loaded("we_chg12", hl);
        n_cmp++; if (log_q.size() != 32) begin n_bad++; $display("FAIL we_chg_count: got %0d want 32", log_q.size()); end
        n_cmp++; if (log_q.size() > 16 && (log_q[0].wr !== 1'b1 || log_q[0].lba !== 32'd2640 ||
                                            log_q[16].wr !== 1'b0 || log_q[16].lba !== 32'd2656)) begin
            n_bad++;
            $display("FAIL we_chg_seq: first wr=%b lba=%0d, 17th wr=%b lba=%0d; want 1/2640, 0/2656",
                     log_q[0].wr, log_q[0].lba, log_q[16].wr, log_q[16].lba);
        end
    endtask

    task automatic test_readonly();
        log_q.delete();
        img_readonly = 1'b1;
        repeat (3) begin
            we = 1'b1; cyc(1);
            we = 1'b0; cyc(1);
        end
        mtr = 1'b0;
        cyc(20);
        n_cmp++; if (log_q.size() != 0) begin n_bad++; $display("FAIL ro_xfers: got %0d want 0", log_q.size()); end
        n_cmp++; if (loaded !== 1'b0 || halt !== 1'b1) begin
            n_bad++; $display("FAIL ro_unloaded: loaded=%b halt=%b want 0/1", loaded, halt);
        end
        n_cmp++; if (dut.state_q !== 3'd0) begin n_bad++; $display("FAIL ro_state: got %0d want 0 (IDLE)", dut.state_q); end
        img_readonly = 1'b0;
    endtask

    task automatic test_mount_during_save();
        int hl;
        int k;
        drv_act = 1'b1; track = 8'd20; mtr = 1'b1;
        wait_loaded("goto_1_20", hl);
        log_q.delete();
        we = 1'b1; cyc(1);
        we = 1'b0; track = 8'd21;
        for (k = 0; k < 200 && log_q.size() < 4; k++) cyc(1);
        img_mounted = 1'b1; mtr = 1'b0;
        cyc(1);
        img_mounted = 1'b0;
        for (k = 0; k < 400 && log_q.size() < 16; k++) cyc(1);
        cyc(30);
        n_cmp++; if (log_q.size() != 16) begin n_bad++; $display("FAIL mnt_count: got %0d want 16", log_q.size()); end
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            n_cmp++;
            if (log_q[i].wr !== 1'b1 || log_q[i].lba !== 32'(2784 + i)) begin
                n_bad++;
                $display("FAIL mnt_xfer%0d: got wr=%b lba=%0d want wr=1 lba=%0d", i, log_q[i].wr, log_q[i].lba, 2784 + i);
            end
        end
        n_cmp++; if (loaded !== 1'b0) begin n_bad++; $display("FAIL mnt_loaded: got %b want 0", loaded); end
        n_cmp++; if (dut.cur_trk_q !== 8'hFF) begin n_bad++; $display("FAIL mnt_cur_trk: got %h want ff", dut.cur_trk_q); end
    endtask

    task automatic test_reset_mid_read();
        int k;
        drv_act = 1'b0; track = 8'd30; mtr = 1'b1;
        for (k = 0; k < 100 && sd.sd_rd !== 1'b1; k++) cyc(1);
        n_cmp++; if (sd.sd_rd !== 1'b1) begin n_bad++; $display("FAIL rst_rd_start: sd_rd=%b want 1", sd.sd_rd); end
        reset_n = 1'b0;
        @(posedge clk_sys); #1;
        n_cmp++; if (sd.sd_rd !== 1'b0 || halt !== 1'b1 || loaded !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_read: sd_rd=%b halt=%b loaded=%b want 0/1/0", sd.sd_rd, halt, loaded);
        end
        mtr = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(5);
    endtask

    initial begin
        test_reset();
        test_load_from_reset();
        test_clean_change();
        test_dirty_change();
        test_we_with_change();
        test_readonly();
        test_mount_during_save();
        test_reset_mid_read();
        n_cmp++;
        if (both_seen) begin n_bad++; $display("FAIL rd_wr_exclusive: both asserted together, want never"); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
